// File: rtl/rm802_mux.sv
// ---------------------------------------------------------------------------
// rm802_mux
//
// Registered 2:1 word multiplexer used as a datapath bus source selector
// (for example in front of register or ALU operand inputs). On every rising
// clock edge it loads either operand a or operand b into y, or forces y to
// zero while the active-low enable is deasserted. Latency is exactly one
// clock, with no handshake and no throughput limit.
//
// Parameters:
//   WIDTH     data width of a, b and y (1..64)
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous reset, active-high
//   a         in   WIDTH  operand A, chosen when select=0
//   b         in   WIDTH  operand B, chosen when select=1
//   select    in   1      0 chooses a, 1 chooses b
//   enable_n  in   1      active-low enable; 1 forces y to zero
//   y         out  WIDTH  registered multiplexer result
//   y_active  out  1      1 when y holds a selected operand, 0 when forced zero
//   sel_q     out  1      select value used for the current y; 0 when forced zero
//   y_parity  out  1      XOR reduction of y (only with RM802_MUX_PARITY_EN)
//
// Optional feature:
//   Define RM802_MUX_PARITY_EN to add the registered even-parity output
//   y_parity. Without the macro the port does not exist and every other
//   behaviour is unchanged.
// ---------------------------------------------------------------------------
module rm802_mux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             select,
    input  logic             enable_n,
    output logic [WIDTH-1:0] y,
    output logic             y_active,
`ifdef RM802_MUX_PARITY_EN
    output logic             sel_q,
    output logic             y_parity
`else
    output logic             sel_q
`endif
);

    // Next-state values for the output registers. Disable takes priority
    // over select, so a disabled cycle always loads zeros regardless of
    // a, b or select.
    logic [WIDTH-1:0] w_y_next;
    logic             w_active_next;
    logic             w_sel_next;

    // Output registers; these are the only state in the block.
    logic [WIDTH-1:0] r_y;
    logic             r_active;
    logic             r_sel;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        w_y_next      = '0;
        w_active_next = 1'b0;
        w_sel_next    = 1'b0;
        if (!enable_n) begin
            w_y_next      = select ? b : a;
            w_active_next = 1'b1;
            w_sel_next    = select;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_y      <= '0;
            r_active <= 1'b0;
            r_sel    <= 1'b0;
        end else begin
            r_y      <= w_y_next;
            r_active <= w_active_next;
            r_sel    <= w_sel_next;
        end
    end

    assign y        = r_y;
    assign y_active = r_active;
    assign sel_q    = r_sel;

`ifdef RM802_MUX_PARITY_EN
    // Parity is registered alongside y from the same next-state value, so it
    // never lags y and is naturally 0 on reset and while disabled.
    logic r_parity;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= ^w_y_next;
        end
    end

    assign y_parity = r_parity;
`endif

endmodule

// File: tb/tb_rm802_mux.sv
// ---------------------------------------------------------------------------
// tb_rm802_mux
//
// Self-checking bench for rm802_mux (WIDTH=8). Directed steps cover reset,
// select A/B, disable, back-to-back changes and mid-stream reset, followed by
// randomized cycles. Expected outputs come from a behavioural model written
// directly from the mux rules: y is zero when reset or disabled, otherwise
// the chosen operand, always one edge after the inputs are applied.
// ---------------------------------------------------------------------------
module tb_rm802_mux;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             select;
    logic             enable_n;
    logic [WIDTH-1:0] y;
    logic             y_active;
    logic             sel_q;
`ifdef RM802_MUX_PARITY_EN
    logic             y_parity;
`endif

    int errors = 0;
    int checks = 0;

    rm802_mux #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .select   (select),
        .enable_n (enable_n),
        .y        (y),
        .y_active (y_active),
`ifdef RM802_MUX_PARITY_EN
        .sel_q    (sel_q),
        .y_parity (y_parity)
`else
        .sel_q    (sel_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Apply one set of inputs, clock one edge, then compare all outputs with
    // the model's prediction for that edge.
    task automatic step(input string tag, input logic i_rst,
                        input logic [WIDTH-1:0] i_a, input logic [WIDTH-1:0] i_b,
                        input logic i_sel, input logic i_en_n);
        logic [WIDTH-1:0] exp_y;
        logic             exp_active;
        logic             exp_sel;
        rst      = i_rst;
        a        = i_a;
        b        = i_b;
        select   = i_sel;
        enable_n = i_en_n;
        if (i_rst || i_en_n) begin
            exp_y      = '0;
            exp_active = 1'b0;
            exp_sel    = 1'b0;
        end else begin
            exp_y      = i_sel ? i_b : i_a;
            exp_active = 1'b1;
            exp_sel    = i_sel;
        end
        @(posedge clk);
        #1;
        check({tag, ".y"}, 64'(y), 64'(exp_y));
        check({tag, ".y_active"}, 64'(y_active), 64'(exp_active));
        check({tag, ".sel_q"}, 64'(sel_q), 64'(exp_sel));
`ifdef RM802_MUX_PARITY_EN
        begin
            int ones = 0;
            for (int k = 0; k < WIDTH; k++) ones += int'(exp_y[k]);
            check({tag, ".y_parity"}, 64'(y_parity), 64'(ones % 2));
        end
`endif
        #4;
    endtask

    initial begin
        rst      = 1'b1;
        a        = '0;
        b        = '0;
        select   = 1'b0;
        enable_n = 1'b1;
        #2;

        // Reset held for two edges with an otherwise active input pattern.
        step("reset0", 1'b1, 8'hAA, 8'h55, 1'b1, 1'b0);
        step("reset1", 1'b1, 8'hAA, 8'h55, 1'b1, 1'b0);

        step("sel_a",   1'b0, 8'b10101010, 8'b01010101, 1'b0, 1'b0);
        step("sel_b",   1'b0, 8'b10101010, 8'b01010101, 1'b1, 1'b0);
        step("disable", 1'b0, 8'b10101010, 8'b01010101, 1'b0, 1'b1);
        step("dis_selb", 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1);

        // Back-to-back select change; both values have even parity.
        step("b2b_a", 1'b0, 8'b11110000, 8'b00001111, 1'b0, 1'b0);
        step("b2b_b", 1'b0, 8'b11110000, 8'b00001111, 1'b1, 1'b0);

        // Reset for one edge mid-stream, then immediate recovery.
        step("mid_rst",  1'b1, 8'hF0, 8'h0F, 1'b1, 1'b0);
        step("post_rst", 1'b0, 8'hF0, 8'h0F, 1'b1, 1'b0);

        // Simultaneous select and enable changes, odd-parity values.
        step("sim_chg0", 1'b0, 8'h01, 8'h80, 1'b0, 1'b0);
        step("sim_chg1", 1'b0, 8'h01, 8'h80, 1'b1, 1'b1);
        step("sim_chg2", 1'b0, 8'h07, 8'h80, 1'b0, 1'b0);

        // Randomized cycles with occasional reset and disable.
        for (int i = 0; i < 300; i++) begin
            step("rand",
                 ($urandom_range(0, 15) == 0),
                 WIDTH'($urandom),
                 WIDTH'($urandom),
                 1'($urandom),
                 ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net: the bench is edge-driven and cannot stall, but never hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rm802_mux.md
Name: rm802_mux

Overview:
- Registered 2:1 word multiplexer with active-low output enable and synchronous active-high reset.
- Selects operand a or b onto y, or forces y to zero when disabled.
- Used in the datapath as a bus source selector, e.g. in front of register/ALU operand inputs.
- One-cycle registered latency; no handshake.

Parameters:
- WIDTH, 8, data width of a, b and y (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- a  input  WIDTH  operand A, chosen when select=0.
- b  input  WIDTH  operand B, chosen when select=1.
- select  input  1  source select: 0 chooses a, 1 chooses b.
- enable_n  input  1  active-low enable; 1 forces y to all zeros.
- y  output  WIDTH  registered multiplexer result.
- y_active  output  1  registered flag; 1 when y holds a selected operand, 0 when y is forced zero.
- sel_q  output  1  registered copy of the select value used for the current y; 0 when y is forced zero.

Behaviour:
- All outputs are registers updated only on the rising edge of clk. Inputs are sampled at that edge; there are no combinational input-to-output paths.
- Reset (rst=1 at an edge):
  - y=0, y_active=0, sel_q=0.
  - Reset overrides every other input, including assertion mid-stream; the next edge after rst drops resumes normal operation.
- Normal edge, rst=0:
  - enable_n=1: y=0, y_active=0, sel_q=0. a, b and select are ignored.
  - enable_n=0, select=0: y=a, y_active=1, sel_q=0.
  - enable_n=0, select=1: y=b, y_active=1, sel_q=1.
- Latency: exactly 1 clock from input sampling to y. Back-to-back input changes on consecutive cycles each appear on y one cycle later. No bubbles and no throughput limit.
- Data is passed bit-exact; no arithmetic, truncation or extension. WIDTH applies uniformly to a, b and y.
- Simultaneous changes of select and enable_n take effect at the same edge, using the rules above. Disable has priority over select.
- Unknown or X values on select or enable_n carry no defined behaviour; benches drive known values only.
- No internal state beyond the output registers. After reset, output depends only on the inputs sampled at the previous edge.

Optional Feature:
- Macro RM802_MUX_PARITY_EN.
- Defined:
  - Adds output port y_parity (1 bit), registered with y.
  - y_parity equals the XOR reduction of the value loaded into y (even-parity bit).
  - y_parity is 0 on reset and 0 while disabled, since y=0.
- Not defined: port y_parity does not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 edges with a=8'hAA, b=8'h55, select=1, enable_n=0 -> y=8'h00, y_active=0, sel_q=0 after each edge.
- Select A: rst=0, a=8'b10101010, b=8'b01010101, select=0, enable_n=0 -> one edge later y=8'b10101010, y_active=1, sel_q=0.
- Select B: same a/b, select=1, enable_n=0 -> next edge y=8'b01010101, y_active=1, sel_q=1.
- Disabled: same a/b, select=0, enable_n=1 -> next edge y=8'b00000000, y_active=0, sel_q=0.
- Different inputs / back-to-back: a=8'b11110000, b=8'b00001111, select=0, enable_n=0, then select=1 on the next cycle -> y=8'hF0 then 8'h0F on consecutive edges. With RM802_MUX_PARITY_EN, y_parity=0 for both values.
- Reset mid-operation: while enable_n=0, select=1, b=8'h0F, assert rst for one edge -> y=0 at that edge. After rst deasserts, the next edge gives y=8'h0F.
